// File: rtl/nco_pkg.sv
// Shared constants, quadrant encoding and quarter-wave table generator for the I/Q NCO.
// Latency: n/a (package).  Backpressure: n/a.
package nco_pkg;

    localparam int  NCO_LATENCY = 3;
    localparam real NCO_PI      = 3.14159265358979323846;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quad_e;

    // Half-step sampled quarter sine, so entry k and entry N-1-k are exact sin/cos mirrors.
    function automatic logic [31:0] lut_entry(input int k, input int addr_w, input int amp_w);
        real amp;
        real ang;
        amp = real'((1 << (amp_w - 1)) - 1);
        ang = NCO_PI / 2.0 * (real'(k) + 0.5) / real'(1 << addr_w);
        return $rtoi(amp * $sin(ang) + 0.5);
    endfunction

endpackage

// File: rtl/nco_quarter_lut.sv
// Dual-address quarter-wave magnitude ROM with a registered read port per address.
// Latency: 1 cycle.  Backpressure: none, reads every cycle.
module nco_quarter_lut
    import nco_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int AMP_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [AMP_W-2:0]  dat_a,
    output logic [AMP_W-2:0]  dat_b
);

    localparam int N     = 1 << ADDR_W;
    localparam int MAG_W = AMP_W - 1;

    logic [MAG_W-1:0] rom [N];
    logic [MAG_W-1:0] dat_a_d, dat_a_q;
    logic [MAG_W-1:0] dat_b_d, dat_b_q;

    for (genvar k = 0; k < N; k++) begin : g_rom
        assign rom[k] = MAG_W'(lut_entry(k, ADDR_W, AMP_W));
    end

    always_comb begin
        dat_a_d = rom[addr_a];
        dat_b_d = rom[addr_b];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dat_a_q <= '0;
            dat_b_q <= '0;
        end else begin
            dat_a_q <= dat_a_d;
            dat_b_q <= dat_b_d;
        end
    end

    assign dat_a = dat_a_q;
    assign dat_b = dat_b_q;

endmodule

// File: rtl/nco_iq_lut.sv
// Phase-accumulator NCO producing signed sin/cos from a quarter-wave LUT plus aligned square outputs.
// Latency: 3 cycles from accumulator register to outputs.  Backpressure: none, en only gates the accumulator.
module nco_iq_lut
    import nco_pkg::*;
#(
    parameter int PHASE_W    = 64,
    parameter int LUT_ADDR_W = 8,
    parameter int AMP_W      = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [PHASE_W-1:0]       phase_inc,
    input  logic                     inc_load,
    input  logic [LUT_ADDR_W+1:0]    phase_off,
    input  logic                     phase_clr,
    output logic signed [AMP_W-1:0]  sin_out,
    output logic signed [AMP_W-1:0]  cos_out,
    output logic                     sin_sq,
    output logic                     cos_sq,
    output logic                     out_valid,
    output logic [PHASE_W-1:0]       phase_accum
);

    localparam int TP_W  = LUT_ADDR_W + 2;
    localparam int MAG_W = AMP_W - 1;

    logic [PHASE_W-1:0]     acc_d, acc_q;
    logic [PHASE_W-1:0]     inc_d, inc_q;
    logic [TP_W-1:0]        p_d, p_q;
    quad_e                  quad_d, quad_q;
    logic [1:0]             sq2_d, sq2_q;
    logic signed [AMP_W-1:0] sin_d, sin_q;
    logic signed [AMP_W-1:0] cos_d, cos_q;
    logic                   sin_sq_d, sin_sq_q;
    logic                   cos_sq_d, cos_sq_q;
    logic [NCO_LATENCY-1:0] vld_d, vld_q;

    logic [LUT_ADDR_W-1:0]  idx;
    logic [MAG_W-1:0]       lut_a, lut_b;
    logic signed [AMP_W-1:0] pos_a, pos_b;

    assign idx = p_q[LUT_ADDR_W-1:0];

    nco_quarter_lut #(
        .ADDR_W (LUT_ADDR_W),
        .AMP_W  (AMP_W)
    ) u_lut (
        .clk    (clk),
        .rst    (rst),
        .addr_a (idx),
        .addr_b (~idx),
        .dat_a  (lut_a),
        .dat_b  (lut_b)
    );

    always_comb begin
        // Clear wins over advance; the load takes effect only from the next cycle.
        acc_d = acc_q;
        if (phase_clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + inc_q;
        end
        inc_d = inc_load ? phase_inc : inc_q;

        p_d    = acc_q[PHASE_W-1 -: TP_W] + phase_off;
        quad_d = quad_e'(p_q[TP_W-1 -: 2]);
        sq2_d  = {~p_q[TP_W-1], ~(p_q[TP_W-1] ^ p_q[TP_W-2])};
        vld_d  = {vld_q[NCO_LATENCY-2:0], en};

        pos_a = {1'b0, lut_a};
        pos_b = {1'b0, lut_b};
        sin_d = pos_a;
        cos_d = pos_b;
        case (quad_q)
            Q0: begin sin_d =  pos_a; cos_d =  pos_b; end
            Q1: begin sin_d =  pos_b; cos_d = -pos_a; end
            Q2: begin sin_d = -pos_a; cos_d = -pos_b; end
            Q3: begin sin_d = -pos_b; cos_d =  pos_a; end
            default: ;
        endcase
        sin_sq_d = sq2_q[1];
        cos_sq_d = sq2_q[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            inc_q    <= '0;
            p_q      <= '0;
            quad_q   <= Q0;
            sq2_q    <= '0;
            sin_q    <= '0;
            cos_q    <= '0;
            sin_sq_q <= 1'b0;
            cos_sq_q <= 1'b0;
            vld_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            inc_q    <= inc_d;
            p_q      <= p_d;
            quad_q   <= quad_d;
            sq2_q    <= sq2_d;
            sin_q    <= sin_d;
            cos_q    <= cos_d;
            sin_sq_q <= sin_sq_d;
            cos_sq_q <= cos_sq_d;
            vld_q    <= vld_d;
        end
    end

    assign sin_out     = sin_q;
    assign cos_out     = cos_q;
    assign sin_sq      = sin_sq_q;
    assign cos_sq      = cos_sq_q;
    assign out_valid   = vld_q[NCO_LATENCY-1];
    assign phase_accum = acc_q;

endmodule

// File: tb/tb_nco_iq_lut.sv
// Directed stimulus for nco_iq_lut with a trigonometric reference model compared every cycle.
module tb_nco_iq_lut;

    localparam real PI = 3.14159265358979323846;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic [63:0]        phase_inc = '0;
    logic               inc_load = 1'b0;
    logic [9:0]         phase_off = '0;
    logic               phase_clr = 1'b0;
    logic signed [11:0] sin_out;
    logic signed [11:0] cos_out;
    logic               sin_sq;
    logic               cos_sq;
    logic               out_valid;
    logic [63:0]        phase_accum;

    int tests  = 0;
    int failed = 0;

    nco_iq_lut dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .phase_inc   (phase_inc),
        .inc_load    (inc_load),
        .phase_off   (phase_off),
        .phase_clr   (phase_clr),
        .sin_out     (sin_out),
        .cos_out     (cos_out),
        .sin_sq      (sin_sq),
        .cos_sq      (cos_sq),
        .out_valid   (out_valid),
        .phase_accum (phase_accum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi($floor(x + 0.5));
        return -$rtoi($floor(-x + 0.5));
    endfunction

    // Ideal samples of a full-scale tone at the centre of each of the 1024 phase bins.
    function automatic int ref_sin(input int p);
        return rnd(2047.0 * $sin(2.0 * PI * (real'(p) + 0.5) / 1024.0));
    endfunction

    function automatic int ref_cos(input int p);
        return rnd(2047.0 * $cos(2.0 * PI * (real'(p) + 0.5) / 1024.0));
    endfunction

    // Reference model: checked on every falling edge, then advanced with the inputs for the next rising edge.
    logic [63:0] acc_m = '0;
    logic [63:0] inc_m = '0;
    int          pq[$];
    bit          eq[$];
    bit          rst_last = 1'b1;

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("accum", phase_accum, acc_m);
            if (rst_last) begin
                chk("rst_sin", sin_out, 0);
                chk("rst_cos", cos_out, 0);
                chk("rst_sin_sq", sin_sq, 0);
                chk("rst_cos_sq", cos_sq, 0);
                chk("rst_valid", out_valid, 0);
            end else if (pq.size() == 3) begin
                chk("sin", sin_out, ref_sin(pq[0]));
                chk("cos", cos_out, ref_cos(pq[0]));
                chk("sin_sq", sin_sq, (pq[0] < 512) ? 1 : 0);
                chk("cos_sq", cos_sq, (pq[0] < 256 || pq[0] >= 768) ? 1 : 0);
                chk("valid", out_valid, eq[0]);
            end else begin
                chk("valid_fill", out_valid, 0);
            end

            if (rst) begin
                acc_m    = '0;
                inc_m    = '0;
                pq.delete();
                eq.delete();
                rst_last = 1'b1;
            end else begin
                pq.push_back((int'(acc_m >> 54) + int'(phase_off)) % 1024);
                eq.push_back(en);
                if (pq.size() > 3) begin
                    void'(pq.pop_front());
                    void'(eq.pop_front());
                end
                if (phase_clr) acc_m = '0;
                else if (en)   acc_m = acc_m + inc_m;
                if (inc_load)  inc_m = phase_inc;
                rst_last = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] hold;
        logic [63:0] e_acc;
        int s_tab[4];
        int c_tab[4];
        int ss_tab[4];
        int cs_tab[4];
        s_tab  = '{6, 2047, -6, -2047};
        c_tab  = '{2047, -6, -2047, 6};
        ss_tab = '{1, 1, 0, 0};
        cs_tab = '{1, 0, 0, 1};

        // Reset with random inputs
        for (int i = 0; i < 5; i++) begin
            en        = 1'($urandom);
            phase_inc = {$urandom, $urandom};
            inc_load  = 1'($urandom);
            phase_off = 10'($urandom);
            phase_clr = 1'($urandom);
            tick();
        end
        chk("lit_rst_accum", phase_accum, 0);
        chk("lit_rst_sin", sin_out, 0);
        chk("lit_rst_valid", out_valid, 0);

        // Quarter-rate tone
        rst = 1'b0; en = 1'b0; phase_clr = 1'b0; phase_off = '0;
        inc_load = 1'b1; phase_inc = 64'd1 << 62;
        tick();
        inc_load = 1'b0; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            e_acc = 64'(i + 1) << 62;
            chk("lit_qr_accum", phase_accum, e_acc);
            if (i >= 2) begin
                chk("lit_qr_sin", sin_out, s_tab[i-2]);
                chk("lit_qr_cos", cos_out, c_tab[i-2]);
                chk("lit_qr_sin_sq", sin_sq, ss_tab[i-2]);
                chk("lit_qr_cos_sq", cos_sq, cs_tab[i-2]);
                chk("lit_qr_valid", out_valid, 1);
            end
        end

        // Phase offset with a stationary accumulator
        phase_clr = 1'b1; inc_load = 1'b1; phase_inc = '0; phase_off = 10'd256;
        tick();
        phase_clr = 1'b0; inc_load = 1'b0;
        repeat (3) tick();
        chk("lit_off256_sin", sin_out, 2047);
        chk("lit_off256_cos", cos_out, -6);
        phase_off = 10'd512;
        repeat (3) tick();
        chk("lit_off512_sin", sin_out, -6);
        chk("lit_off512_cos", cos_out, -2047);

        // Clear and load in the same cycle
        phase_off = '0; inc_load = 1'b1; phase_inc = 64'd1 << 58;
        tick();
        inc_load = 1'b0;
        repeat (5) tick();
        phase_clr = 1'b1; inc_load = 1'b1; phase_inc = 64'd1 << 60;
        tick();
        chk("lit_clr_accum0", phase_accum, 0);
        phase_clr = 1'b0; inc_load = 1'b0;
        tick();
        chk("lit_clr_accum1", phase_accum, 64'd1 << 60);
        tick();
        chk("lit_clr_accum2", phase_accum, 64'd1 << 61);

        // Wrap with an all-ones increment
        phase_clr = 1'b1; inc_load = 1'b1; phase_inc = '1;
        tick();
        phase_clr = 1'b0; inc_load = 1'b0;
        tick();
        chk("lit_wrap_accum", phase_accum, 64'hFFFF_FFFF_FFFF_FFFF);
        repeat (3) tick();
        chk("lit_wrap_sin", sin_out, -6);
        chk("lit_wrap_cos", cos_out, 2047);
        chk("lit_wrap_sin_sq", sin_sq, 0);
        chk("lit_wrap_cos_sq", cos_sq, 1);

        // Enable drop and return
        inc_load = 1'b1; phase_inc = 64'd1 << 61;
        tick();
        inc_load = 1'b0;
        repeat (4) tick();
        hold = phase_accum;
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("lit_hold_accum", phase_accum, hold);
            chk("lit_drop_valid", out_valid, (i < 2) ? 1 : 0);
        end
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lit_rise_valid", out_valid, (i == 2) ? 1 : 0);
        end

        // Reset mid-operation
        rst = 1'b1;
        tick();
        chk("lit_midrst_accum", phase_accum, 0);
        chk("lit_midrst_cos", cos_out, 0);
        chk("lit_midrst_valid", out_valid, 0);
        rst = 1'b0;
        repeat (6) tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/nco_iq_lut.md
Name: nco_iq_lut

Overview:
- Parametrised successor to the team's 1-bit square-wave NCO.
- Adds synchronous reset, a registered frequency-load strobe, a phase offset, phase clear and an enable.
- Produces multi-bit signed sine/cosine from a quarter-wave LUT, plus delay-aligned 1-bit square outputs.
- Sits between frequency control logic and the I/Q mixer of the SDR receive chain.

Parameters:
- PHASE_W, 64: accumulator and phase-increment width.
- LUT_ADDR_W, 8: quarter-wave LUT address bits; N = 2^LUT_ADDR_W entries.
- AMP_W, 12: signed sine/cosine output width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  accumulator advance enable.
- phase_inc  in  PHASE_W  new frequency word.
- inc_load  in  1  captures phase_inc into inc_reg.
- phase_off  in  LUT_ADDR_W+2  phase offset in truncated-phase units (mod 2π).
- phase_clr  in  1  zeroes the accumulator.
- sin_out  out  AMP_W  signed sine sample.
- cos_out  out  AMP_W  signed cosine sample.
- sin_sq  out  1  square sine: 1 when truncated phase MSB = 0.
- cos_sq  out  1  square cosine: 1 when the two truncated-phase MSBs are equal.
- out_valid  out  1  high when the outputs derive from an enabled sample.
- phase_accum  out  PHASE_W  current accumulator register.

Behaviour:
- Reset: phase_accum, inc_reg, all pipeline registers, sin_out, cos_out, sin_sq, cos_sq and out_valid are 0. rst overrides every other input.
- Increment register: inc_reg <= phase_inc when inc_load = 1. In the load cycle the accumulator still adds the old inc_reg, so a new word takes effect one cycle later.
- Accumulator priority, highest first: rst; then phase_clr (acc <= 0, regardless of en); then en (acc <= acc + inc_reg, modulo 2^PHASE_W, silent wrap); otherwise hold.
- Stage 1 (register):
  - p = acc[PHASE_W-1 -: LUT_ADDR_W+2] + phase_off, modulo 2^(LUT_ADDR_W+2).
  - q = p[top 2 bits], idx = remaining bits.
  - phase_off is sampled live; no load strobe.
- Stage 2 (register): LUT read of lut[idx] and lut[N-1-idx]; q is carried along.
- LUT contents: lut[k] = round((2^(AMP_W-1)-1) * sin(π/2*(k+0.5)/N)), stored unsigned. The half-step offset makes the mirroring exact.
- Stage 3 (register, outputs):
  - sin: q0 +lut[idx]; q1 +lut[N-1-idx]; q2 -lut[idx]; q3 -lut[N-1-idx].
  - cos: q0 +lut[N-1-idx]; q1 -lut[idx]; q2 -lut[N-1-idx]; q3 +lut[idx].
  - Magnitude never exceeds 2^(AMP_W-1)-1, so negation cannot overflow.
- Square outputs: sin_sq = ~p[MSB], cos_sq = ~(p[MSB]^p[MSB-1]), computed from p and delayed to align with sin_out/cos_out.
- Latency: an accumulator value appears at the outputs 3 cycles after it is registered.
- out_valid: en delayed through a 3-deep shift register, aligned with the data.
- Pipeline stages after the accumulator run every cycle regardless of en; data stays deterministic while en = 0.
- Simultaneous phase_clr and inc_load: both act. The accumulator is 0 next cycle, then advances by the new inc_reg.
- Reset asserted mid-operation: all state, including the 3-stage pipeline, is 0 on the next edge. No stale samples emerge after release.

Decomposition:
- Package nco_pkg holds:
  - constant NCO_LATENCY = 3;
  - quadrant typedef (Q0..Q3);
  - function computing lut[k] from LUT_ADDR_W and AMP_W, used for ROM initialisation.
- One sub-module, nco_quarter_lut: dual-address synchronous ROM, N x (AMP_W-1) bits, one-cycle read latency, infers block RAM or LUTs.

Test Plan:
All scenarios use defaults: PHASE_W=64, LUT_ADDR_W=8, AMP_W=12. This gives lut[0]=6 and lut[255]=2047.
1. Reset: rst = 1 for 5 cycles with random inputs -> all outputs 0, phase_accum 0, out_valid 0.
2. Quarter-rate tone: inc_load with phase_inc = 2^62, then en = 1, phase_off = 0.
   - phase_accum sequence: 0, 2^62, 2^63, 3*2^62, 0, …
   - Expected sin_out / cos_out, first valid sample 3 cycles after accumulator value 0:
     - q0: +6 / +2047
     - q1: +2047 / -6
     - q2: -6 / -2047
     - q3: -2047 / +6
   - Expected sin_sq / cos_sq: 1/1, 1/0, 0/0, 0/1.
3. Offset: inc = 0, acc = 0, phase_off = 256 -> sin_out = 2047, cos_out = -6 after 3 cycles. Change phase_off to 512 -> sin_out = -6, cos_out = -2047.
4. Clear with load: mid-run, assert phase_clr and inc_load (phase_inc = 2^60) in the same cycle -> phase_accum 0 next cycle, then 2^60, 2^61.
5. Wrap: phase_inc = 2^64-1 from acc = 0 -> phase_accum = 2^64-1, sin_out = -6, cos_out = +2047 three cycles later; no X, wraps silently.
6. Enable drop: deassert en for 4 cycles -> phase_accum holds; out_valid falls 3 cycles after en falls and rises 3 cycles after en returns.
